alu_pipe: RTL and testbench

- Parametrised successor to the team's 18-bit single-cycle ALU.
- Adds a valid/ready handshake on input and output, and an iterative multi-cycle unsigned divide/modulo unit.
- Computes true signed overflow, adds an XOR op and a divide-by-zero flag.
- Sits between the datapath operand registers and the writeback stage; one operation in flight at a time.

---
 rtl/alu_pipe.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: 18-bit (parametrised) ALU with valid/ready handshakes on both sides,
// true signed overflow, XOR, and an iterative restoring unsigned divider.
// Only one operation is ever in flight. Results and flags live in output
// registers that load only when out_valid is (re)asserted.
module alu_pipe #(
   parameter int WIDTH      = 18,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] datA,
   input  logic [WIDTH-1:0] datB,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             AgtB,
   output logic             N,
   output logic             Z,
   output logic             dz
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Single-cycle operations, returned as {ovf, result}. For DIV/MOD this only
   // covers the zero-divisor case; real divides go through the iterative unit.
   function automatic logic [WIDTH:0] f_basic(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0]   v_sum;
      logic [2*WIDTH-1:0] v_prod;
      logic [WIDTH:0]     v_out;
      v_sum  = {WIDTH{1'b0}};
      v_prod = {(2*WIDTH){1'b0}};
      v_out  = {(WIDTH+1){1'b0}};
      case (op)
         OP_ADD: begin
            v_sum = a + b;
            v_out = {(a[WIDTH-1] == b[WIDTH-1]) && (v_sum[WIDTH-1] != a[WIDTH-1]), v_sum};
         end
         OP_SUB: begin
            v_sum = a - b;
            v_out = {(a[WIDTH-1] != b[WIDTH-1]) && (v_sum[WIDTH-1] != a[WIDTH-1]), v_sum};
         end
         OP_MUL: begin
            v_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            v_out  = {|v_prod[2*WIDTH-1:WIDTH], v_prod[WIDTH-1:0]};
         end
         OP_DIV:  v_out = {1'b1, {WIDTH{1'b1}}};
         OP_MOD:  v_out = {1'b1, a};
         OP_OR:   v_out = {1'b0, a | b};
         OP_AND:  v_out = {1'b0, a & b};
         OP_XOR:  v_out = {1'b0, a ^ b};
         default: v_out = {(WIDTH+1){1'b0}};
      endcase
      return v_out;
   endfunction

   // Optional final left shift; ovf also flags a shifted-out bit that differs
   // from the new MSB (i.e. the shift changed the sign).
   function automatic logic [WIDTH:0] f_shift(input logic [WIDTH:0] v_in,
                                              input logic           sh);
      logic [WIDTH:0] v_out;
      if (sh) begin
         v_out = {v_in[WIDTH] | (v_in[WIDTH-1] ^ v_in[WIDTH-2]),
                  v_in[WIDTH-2:0], 1'b0};
      end else begin
         v_out = v_in;
      end
      return v_out;
   endfunction

   // Operand compare, signedness chosen at elaboration.
   function automatic logic f_agtb(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      logic v_gt;
      if (SIGNED_CMP) begin
         v_gt = $signed(a) > $signed(b);
      end else begin
         v_gt = a > b;
      end
      return v_gt;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   w_b_nxt;
   logic               r_div_mod;
   logic               w_mod_nxt;
   logic               r_div_sh;
   logic               w_sh_nxt;
   logic               r_div_agtb;
   logic               w_dagtb_nxt;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   w_res_nxt;
   logic               r_ovf;
   logic               w_ovf_nxt;
   logic               r_agtb;
   logic               w_agtb_nxt;
   logic               r_n;
   logic               w_n_nxt;
   logic               r_z;
   logic               w_z_nxt;
   logic               r_dz;
   logic               w_dz_nxt;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_div;
   logic               w_b_zero;
   logic [WIDTH:0]     w_direct;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_trial;
   logic               w_fits;
   logic [WIDTH-1:0]   w_rem_step;
   logic [WIDTH-1:0]   w_quo_step;
   logic [WIDTH:0]     w_div_raw;
   logic [WIDTH:0]     w_div_fin;

   // A new op may enter when idle, or in the same cycle the held result leaves.
   assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_is_div   = (ctrl[2:0] == OP_DIV) || (ctrl[2:0] == OP_MOD);
   assign w_b_zero   = (datB == {WIDTH{1'b0}});
   assign w_direct   = f_shift(f_basic(ctrl[2:0], datA, datB), ctrl[3]);

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits.
   assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
   assign w_trial    = w_rem_sh - {1'b0, r_b};
   assign w_fits     = ~w_trial[WIDTH];
   assign w_rem_step = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_step = {r_quo[WIDTH-2:0], w_fits};
   assign w_div_raw  = r_div_mod ? {1'b0, w_rem_step} : {1'b0, w_quo_step};
   assign w_div_fin  = f_shift(w_div_raw, r_div_sh);

   // Next-state and next-register values for the sequencer and datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      w_cnt_nxt   = r_cnt;
      w_rem_nxt   = r_rem;
      w_quo_nxt   = r_quo;
      w_b_nxt     = r_b;
      w_mod_nxt   = r_div_mod;
      w_sh_nxt    = r_div_sh;
      w_dagtb_nxt = r_div_agtb;
      w_res_nxt   = r_result;
      w_ovf_nxt   = r_ovf;
      w_agtb_nxt  = r_agtb;
      w_n_nxt     = r_n;
      w_z_nxt     = r_z;
      w_dz_nxt    = r_dz;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               if (w_is_div && !w_b_zero) begin
                  w_state_nxt = ST_DIV;
                  w_valid_nxt = 1'b0;
                  w_cnt_nxt   = CNT_W'(WIDTH-1);
                  w_rem_nxt   = {WIDTH{1'b0}};
                  w_quo_nxt   = datA;
                  w_b_nxt     = datB;
                  w_mod_nxt   = (ctrl[2:0] == OP_MOD);
                  w_sh_nxt    = ctrl[3];
                  w_dagtb_nxt = f_agtb(datA, datB);
               end else begin
                  w_state_nxt = ST_DONE;
                  w_valid_nxt = 1'b1;
                  w_res_nxt   = w_direct[WIDTH-1:0];
                  w_ovf_nxt   = w_direct[WIDTH];
                  w_n_nxt     = w_direct[WIDTH-1];
                  w_z_nxt     = (w_direct[WIDTH-1:0] == {WIDTH{1'b0}});
                  w_agtb_nxt  = f_agtb(datA, datB);
                  w_dz_nxt    = w_is_div && w_b_zero;
               end
            end else if ((r_state == ST_DONE) && out_ready) begin
               w_state_nxt = ST_IDLE;
               w_valid_nxt = 1'b0;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_DIV: begin
            w_rem_nxt = w_rem_step;
            w_quo_nxt = w_quo_step;
            if (r_cnt == {CNT_W{1'b0}}) begin
               w_state_nxt = ST_DONE;
               w_valid_nxt = 1'b1;
               w_res_nxt   = w_div_fin[WIDTH-1:0];
               w_ovf_nxt   = w_div_fin[WIDTH];
               w_n_nxt     = w_div_fin[WIDTH-1];
               w_z_nxt     = (w_div_fin[WIDTH-1:0] == {WIDTH{1'b0}});
               w_agtb_nxt  = r_div_agtb;
               w_dz_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // Sequencer state register; reset abandons any divide in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Divider working registers and the held result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_cnt      <= {CNT_W{1'b0}};
         r_rem      <= {WIDTH{1'b0}};
         r_quo      <= {WIDTH{1'b0}};
         r_b        <= {WIDTH{1'b0}};
         r_div_mod  <= 1'b0;
         r_div_sh   <= 1'b0;
         r_div_agtb <= 1'b0;
         r_result   <= {WIDTH{1'b0}};
         r_ovf      <= 1'b0;
         r_agtb     <= 1'b0;
         r_n        <= 1'b0;
         r_z        <= 1'b1;
         r_dz       <= 1'b0;
      end else begin
         r_valid    <= w_valid_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rem      <= w_rem_nxt;
         r_quo      <= w_quo_nxt;
         r_b        <= w_b_nxt;
         r_div_mod  <= w_mod_nxt;
         r_div_sh   <= w_sh_nxt;
         r_div_agtb <= w_dagtb_nxt;
         r_result   <= w_res_nxt;
         r_ovf      <= w_ovf_nxt;
         r_agtb     <= w_agtb_nxt;
         r_n        <= w_n_nxt;
         r_z        <= w_z_nxt;
         r_dz       <= w_dz_nxt;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_valid;
   assign result    = r_result;
   assign ovf       = r_ovf;
   assign AgtB      = r_agtb;
   assign N         = r_n;
   assign Z         = r_z;
   assign dz        = r_dz;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed operations with hand-computed
// expectations, plus a behavioural arithmetic model checked every cycle.
module tb_alu_pipe;

   localparam int W    = 18;
   localparam bit SCMP = 1'b0;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] datA      = '0;
   logic [W-1:0] datB      = '0;
   logic [3:0]   ctrl      = 4'd0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         ovf, AgtB, N, Z, dz;

   alu_pipe #(.WIDTH(W), .SIGNED_CMP(SCMP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .datA(datA), .datB(datB), .ctrl(ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .AgtB(AgtB), .N(N), .Z(Z), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf, n, z, agtb, dz;
      int           lat;
      int           acc;
      logic         has_lit;
      logic [W-1:0] l_res;
      logic         l_ovf, l_dz, l_agtb;
   } exp_t;

   exp_t         sb[$];
   exp_t         e_push;
   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   bit           after_rst = 1'b0;

   // hand-computed expectations for the operation being presented
   logic [W-1:0] lit_res;
   logic         lit_ovf, lit_dz, lit_agtb;

   function automatic bit msbf(input longint unsigned x);
      return ((x >> (W-1)) & 64'd1) != 64'd0;
   endfunction

   // Behavioural model: plain integer arithmetic on the operation's rules.
   function automatic exp_t model(input int op, input longint unsigned a,
                                  input longint unsigned b, input bit sh);
      exp_t            e;
      longint unsigned msk, r, p;
      longint          sa, sbv;
      bit              ov, out_bit;
      msk  = (64'd1 << W) - 64'd1;
      ov   = 1'b0;
      r    = 64'd0;
      e.dz = 1'b0;
      case (op)
         0: begin r = (a + b) & msk; ov = (msbf(a) == msbf(b)) && (msbf(r) != msbf(a)); end
         1: begin r = (a - b) & msk; ov = (msbf(a) != msbf(b)) && (msbf(r) != msbf(a)); end
         2: begin p = a * b; r = p & msk; ov = (p >> W) != 64'd0; end
         3: if (b == 0) begin r = msk; ov = 1'b1; e.dz = 1'b1; end else r = a / b;
         4: if (b == 0) begin r = a; ov = 1'b1; e.dz = 1'b1; end else r = a % b;
         5: r = a | b;
         6: r = a & b;
         default: r = a ^ b;
      endcase
      if (sh) begin
         out_bit = msbf(r);
         r = (r << 1) & msk;
         ov = ov | (out_bit != msbf(r));
      end
      sa  = msbf(a) ? longint'(a) - longint'(msk) - 1 : longint'(a);
      sbv = msbf(b) ? longint'(b) - longint'(msk) - 1 : longint'(b);
      e.res  = r[W-1:0];
      e.ovf  = ov;
      e.n    = msbf(r);
      e.z    = (r == 64'd0);
      e.agtb = SCMP ? (sa > sbv) : (a > b);
      e.lat  = ((op == 3 || op == 4) && b != 0) ? W + 1 : 1;
      e.acc  = 0;
      e.has_lit = 1'b0;
      e.l_res = '0; e.l_ovf = 1'b0; e.l_dz = 1'b0; e.l_agtb = 1'b0;
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: checks handshake, timing and outputs every cycle.
   always @(negedge clk) begin
      bit pend, ev, er;
      if (!rst_n) begin
         sb.delete();
         after_rst = 1'b1;
      end else begin
         pend = (sb.size() != 0);
         ev   = pend && ((cyc - sb[0].acc) >= sb[0].lat);
         er   = !pend || (ev && out_ready);
         chk("out_valid", out_valid, ev);
         chk("in_ready", in_ready, er);
         if (ev) begin
            chk("result", result, sb[0].res);
            chk("ovf", ovf, sb[0].ovf);
            chk("N", N, sb[0].n);
            chk("Z", Z, sb[0].z);
            chk("AgtB", AgtB, sb[0].agtb);
            chk("dz", dz, sb[0].dz);
            if (sb[0].has_lit) begin
               chk("lit_result", result, sb[0].l_res);
               chk("lit_ovf", ovf, sb[0].l_ovf);
               chk("lit_dz", dz, sb[0].l_dz);
               chk("lit_AgtB", AgtB, sb[0].l_agtb);
               sb[0].has_lit = 1'b0;
            end
         end
         if (after_rst && !pend) begin
            chk("rst_result", result, 0);
            chk("rst_Z", Z, 1);
            chk("rst_N", N, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_AgtB", AgtB, 0);
            chk("rst_dz", dz, 0);
         end
         if (ev && out_valid && out_ready) begin
            void'(sb.pop_front());
         end else if (ev && ((cyc - sb[0].acc) > sb[0].lat + 20)) begin
            void'(sb.pop_front());
         end
         if (in_valid && in_ready) begin
            e_push = model(int'(ctrl[2:0]), longint'(datA), longint'(datB), ctrl[3]);
            e_push.acc     = cyc;
            e_push.has_lit = 1'b1;
            e_push.l_res   = lit_res;
            e_push.l_ovf   = lit_ovf;
            e_push.l_dz    = lit_dz;
            e_push.l_agtb  = lit_agtb;
            sb.push_back(e_push);
            after_rst = 1'b0;
         end
      end
   end

   // Present one operation and hold it until accepted; then scramble inputs.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sh, input logic [W-1:0] lr, input logic lo,
                        input logic ld, input logic lg);
      datA     = a;
      datB     = b;
      ctrl     = {sh, op};
      lit_res  = lr;
      lit_ovf  = lo;
      lit_dz   = ld;
      lit_agtb = lg;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      datA = ~a;
      datB = ~b;
      ctrl = ~{sh, op};
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      do_op(OP_ADD, 18'h1FFFF, 18'h00001, 1'b0, 18'h20000, 1'b1, 1'b0, 1'b1);
      drain();
      do_op(OP_SUB, 18'd5, 18'd5, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0);
      do_op(OP_MUL, 18'h00400, 18'h00400, 1'b0, 18'd0, 1'b1, 1'b0, 1'b0);
      drain();
      do_op(OP_DIV, 18'd100, 18'd7, 1'b0, 18'd14, 1'b0, 1'b0, 1'b1);
      do_op(OP_MOD, 18'd100, 18'd7, 1'b0, 18'd2, 1'b0, 1'b0, 1'b1);
      drain();
      do_op(OP_DIV, 18'd1234, 18'd0, 1'b0, 18'h3FFFF, 1'b1, 1'b1, 1'b1);
      do_op(OP_MOD, 18'd1234, 18'd0, 1'b0, 18'd1234, 1'b1, 1'b1, 1'b1);
      drain();

      // stalled consumer: result must hold and in_ready stay low
      out_ready = 1'b0;
      do_op(OP_XOR, 18'h20001, 18'h00001, 1'b1, 18'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // further corners, issued back-to-back
      do_op(OP_OR,  18'h0F0F0, 18'h00F0F, 1'b0, 18'h0FFFF, 1'b0, 1'b0, 1'b1);
      do_op(OP_AND, 18'h3FFFF, 18'h12345, 1'b0, 18'h12345, 1'b0, 1'b0, 1'b1);
      do_op(OP_SUB, 18'h20000, 18'h00001, 1'b0, 18'h1FFFF, 1'b1, 1'b0, 1'b1);
      do_op(OP_ADD, 18'd2, 18'd3, 1'b1, 18'd10, 1'b0, 1'b0, 1'b0);
      do_op(OP_MOD, 18'd1234, 18'd0, 1'b1, 18'd2468, 1'b1, 1'b1, 1'b1);
      do_op(OP_DIV, 18'h3FFFF, 18'd1, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 1'b1);
      do_op(OP_DIV, 18'd7, 18'd100, 1'b0, 18'd0, 1'b0, 1'b0, 1'b0);
      do_op(OP_ADD, 18'h3FFFF, 18'h3FFFF, 1'b0, 18'h3FFFE, 1'b0, 1'b0, 1'b0);
      drain();

      // reset in the middle of a divide; nothing from it may appear later
      do_op(OP_DIV, 18'd1000, 18'd3, 1'b0, 18'd333, 1'b0, 1'b0, 1'b1);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_op(OP_ADD, 18'd2, 18'd3, 1'b0, 18'd5, 1'b0, 1'b0, 1'b0);
      drain();
      repeat (25) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
